arith_result_buf: RTL

- Downstream stage of the arithmetic unit. Samples each result the unit produces (out/err, qualified by finish) into a small show-ahead FIFO.
- Presents buffered results to a consumer over a valid/ready handshake.
- Keeps a sticky overflow flag plus saturating result and error counters for software visibility.
- The producer has no backpressure, so this block absorbs bursts while start is held high (one result per cycle).

---
 rtl/arith_pkg.sv | 24 ++
 rtl/arith_sync_fifo.sv | 72 +++++++
 rtl/arith_result_buf.sv | 103 ++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit and its result buffer.
//   RES_W          : producer result width
//   res_rec_t      : buffered result record {err, data}
//   arith_sel_e    : operation select encodings
//   ERR_SENTINEL   : result value the producer emits on error
package arith_pkg;

    localparam int unsigned RES_W = 8;

    typedef struct packed {
        logic             err;
        logic [RES_W-1:0] data;
    } res_rec_t;

    typedef enum logic [1:0] {
        SEL_ADD = 2'd0,
        SEL_SUB = 2'd1,
        SEL_MUL = 2'd2,
        SEL_DIV = 2'd3
    } arith_sel_e;

    localparam logic [RES_W-1:0] ERR_SENTINEL = 8'hFF;

endpackage

// File: rtl/arith_sync_fifo.sv
// Generic show-ahead synchronous FIFO.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous clear of pointers and level
//   push, wdata   : write strobe and data (caller guarantees not full unless popping)
//   pop           : read strobe (caller guarantees not empty)
//   rdata         : head entry, zero when empty
//   level         : occupancy 0..DEPTH
//   full, empty   : derived from level
module arith_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;

    // Occupancy bookkeeping: simultaneous push and pop leave the level unchanged.
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level_q <= level_d;
        end
    end

    // Storage needs no reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign level = level_q;
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/arith_result_buf.sv
// Result buffer behind the arithmetic unit: captures each finished result into a
// show-ahead FIFO, hands entries to a consumer over valid/ready, and keeps a
// sticky overflow flag plus saturating result/error counters.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   i_finish, i_out, i_err   : producer result strobe, data, error flag
//   i_clr                    : synchronous clear of FIFO, counters and overflow
//   o_valid, i_ready         : consumer handshake
//   o_data, o_err            : head entry (zero when empty)
//   o_level, o_full          : occupancy and full indication
//   o_overflow               : sticky, a result was dropped while full
//   o_res_cnt, o_err_cnt     : saturating counts of accepted results / errored results
module arith_result_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RES_W = arith_pkg::RES_W,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_finish,
    input  logic [RES_W-1:0]       i_out,
    input  logic                   i_err,
    input  logic                   i_clr,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [RES_W-1:0]       o_data,
    output logic                   o_err,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_overflow,
    output logic [CNT_W-1:0]       o_res_cnt,
    output logic [CNT_W-1:0]       o_err_cnt
);

    import arith_pkg::*;

    localparam int unsigned REC_W   = RES_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] head;
    logic             push_c;
    logic             pop_c;
    logic             drop_c;
    logic             overflow_q;
    logic [CNT_W-1:0] res_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    // Handshake qualification; clear overrides any traffic in its cycle.
    always_comb begin
        pop_c  = 1'b0;
        push_c = 1'b0;
        drop_c = 1'b0;
        if (!i_clr) begin
            pop_c  = !fifo_empty && i_ready;
            push_c = i_finish && (!fifo_full || pop_c);
            drop_c = i_finish && fifo_full && !pop_c;
        end
    end

    arith_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (i_clr),
        .push  (push_c),
        .wdata ({i_err, i_out}),
        .pop   (pop_c),
        .rdata (head),
        .level (o_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky overflow and saturating counters; dropped results are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            res_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else if (i_clr) begin
            overflow_q <= 1'b0;
            res_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (drop_c) overflow_q <= 1'b1;
            if (push_c && (res_cnt_q != CNT_MAX)) res_cnt_q <= res_cnt_q + CNT_W'(1);
            if (push_c && i_err && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign o_valid    = !fifo_empty;
    assign o_full     = fifo_full;
    assign o_data     = head[RES_W-1:0];
    assign o_err      = head[RES_W];
    assign o_overflow = overflow_q;
    assign o_res_cnt  = res_cnt_q;
    assign o_err_cnt  = err_cnt_q;

endmodule
